// File: rtl/lsu_byte_split.sv
// lsu_byte_split
//   Load/store unit between the execute/memory stage and data_memory.
//   Accepts one request at a time and checks its funct3 encoding, address
//   range and alignment. It then drives data_memory either as one aligned
//   access or as a run of single-byte accesses (misaligned requests, split
//   build only). The extended load data and a fault code are returned over
//   a response handshake.
//
//   Build option: define LSU_MISALIGN_SPLIT_EN to execute misaligned
//   LH/LHU/LW/SH/SW as byte sequences. Without it those requests return
//   fault 01 and make no memory access.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake; req_we, req_funct3, req_addr,
//                     req_wdata are captured on accept
//   resp_valid/ready  response handshake; resp_rdata (extended load data,
//                     0 for stores/faults), resp_fault (00 ok, 01 misaligned,
//                     10 out of range, 11 illegal funct3)
//   mem_addr, mem_wdata, mem_we, mem_ctrl  data_memory port (dm_ctrl encoding)
//   mem_rdata         combinational read data from data_memory
module lsu_byte_split #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [2:0]  mem_ctrl,
  input  logic [31:0] mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, BYTES = 2'd2, RESP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd3} state_t;
`endif

  state_t state, state_next;

  // Captured request; every memory-side output is driven from these.
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  // Request checks, evaluated on the live request inputs at accept.
  logic [2:0]  req_size;
  logic [32:0] req_end;
  logic        req_illegal;
  logic        req_oor;
  logic        req_misaligned;
  logic [1:0]  acc_fault;

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
  end

  // 33-bit sum so that wrap-around past 0xFFFFFFFF shows up as a carry.
  assign req_end = {1'b0, req_addr} + {30'b0, req_size} - 33'd1;

  always_comb begin
    if (req_we)
      req_illegal = (req_funct3 != 3'b000) && (req_funct3 != 3'b001) &&
                    (req_funct3 != 3'b010);
    else
      req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                    (req_funct3 == 3'b111);
  end

  assign req_oor = req_end[32] || (req_end[31:0] >= MEM_BYTES);

  assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  always_comb begin
    if (req_illegal)
      acc_fault = 2'b11;
    else if (req_oor)
      acc_fault = 2'b10;
`ifndef LSU_MISALIGN_SPLIT_EN
    else if (req_misaligned)
      acc_fault = 2'b01;
`endif
    else
      acc_fault = 2'b00;
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  // Byte-sequence datapath: idx walks the bytes, asm collects load bytes
  // little-endian. Only halfwords and words ever take this path.
  logic [1:0]  idx;
  logic [31:0] asm_q;
  logic [31:0] asm_next;
  logic [31:0] asm_ext;
  logic        byte_last;

  assign byte_last = (idx == ((r_f3[1:0] == 2'b01) ? 2'd1 : 2'd3));

  always_comb begin
    asm_next = asm_q;
    asm_next[{idx, 3'b000} +: 8] = mem_rdata[7:0];
  end

  always_comb begin
    case (r_f3)
      3'b000:  asm_ext = {{24{asm_next[7]}}, asm_next[7:0]};
      3'b001:  asm_ext = {{16{asm_next[15]}}, asm_next[15:0]};
      3'b100:  asm_ext = {24'b0, asm_next[7:0]};
      3'b101:  asm_ext = {16'b0, asm_next[15:0]};
      default: asm_ext = asm_next;
    endcase
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (acc_fault != 2'b00)
            state_next = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
          else if (req_misaligned)
            state_next = BYTES;
`endif
          else
            state_next = ACCESS;
        end
      end
      ACCESS: state_next = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
      BYTES: if (byte_last) state_next = RESP;
`endif
      RESP: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_ctrl   = 3'b111;
    case (state)
      ACCESS: begin
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        mem_we    = r_we;
        mem_ctrl  = r_f3;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      BYTES: begin
        mem_addr  = r_addr + {30'b0, idx};
        mem_we    = r_we;
        mem_ctrl  = r_we ? 3'b000 : 3'b100;
        mem_wdata = r_we ? {24'b0, r_wdata[{idx, 3'b000} +: 8]} : '0;
      end
`endif
      default: ;
    endcase
  end

  // Request capture and response datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_f3       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      resp_rdata <= '0;
      resp_fault <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      idx        <= '0;
      asm_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_f3       <= req_funct3;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            resp_fault <= acc_fault;
            resp_rdata <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            idx        <= '0;
            asm_q      <= '0;
`endif
          end
        end
        ACCESS: begin
          if (!r_we)
            resp_rdata <= mem_rdata;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        BYTES: begin
          idx <= idx + 2'd1;
          if (!r_we) begin
            asm_q <= asm_next;
            if (byte_last)
              resp_rdata <= asm_ext;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
